// File: rtl/cmdq_request_latency_tracker_if.sv
// Request, response and latency-record signals between the command-queue requester and the latency tracker.
// The master modport is the requester/consumer side; the slave modport is the tracker.
interface cmdq_request_latency_tracker_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_is_write;
   logic [31:0] req_id;

   logic        resp_fire;
   logic [31:0] resp_id;

   logic        stat_valid;
   logic        stat_ready;
   logic [31:0] stat_id;
   logic [31:0] stat_addr;
   logic        stat_is_write;
   logic [63:0] stat_issue_cycle;
   logic [31:0] stat_latency;

   modport master (
      output req_valid, req_addr, req_is_write, resp_fire, resp_id, stat_ready,
      input  req_ready, req_id, stat_valid, stat_id, stat_addr, stat_is_write,
             stat_issue_cycle, stat_latency
   );

   modport slave (
      input  req_valid, req_addr, req_is_write, resp_fire, resp_id, stat_ready,
      output req_ready, req_id, stat_valid, stat_id, stat_addr, stat_is_write,
             stat_issue_cycle, stat_latency
   );
endinterface

// File: rtl/cmdq_request_latency_tracker.sv
// Tags accepted requests with sequential IDs, pairs responses with them and emits latency records.
// Record visible one cycle after the response (FWFT FIFO); req_ready drops on slot conflict, full FIFO drops records.
module cmdq_request_latency_tracker #(
   parameter int DEPTH      = 16,
   parameter int STAT_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   cmdq_request_latency_tracker_if.slave bus,
   input  logic [63:0]               global_cycle,
   output logic [$clog2(DEPTH):0]    outstanding,
   output logic                      err_unmatched,
   output logic                      err_overflow
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SAW = $clog2(STAT_DEPTH);
   localparam logic [SAW:0] PTR_ONE = 1;
   localparam logic [AW:0]  OUT_ONE = 1;

   typedef struct packed {
      logic [31:0] id;
      logic [31:0] addr;
      logic        is_write;
      logic [63:0] issue_cycle;
      logic [31:0] latency;
   } rec_t;

   logic [31:0] id_cnt;
   logic        tbl_valid    [DEPTH];
   logic [31:0] tbl_id       [DEPTH];
   logic [31:0] tbl_addr     [DEPTH];
   logic        tbl_is_write [DEPTH];
   logic [63:0] tbl_issue    [DEPTH];

   rec_t        fifo_mem [STAT_DEPTH];
   logic [SAW:0] wr_ptr;
   logic [SAW:0] rd_ptr;

   logic [AW-1:0] req_slot;
   logic [AW-1:0] resp_slot;
   logic          accept;
   logic          resp_match;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop;
   logic          push_ok;
   logic [63:0]   lat_diff;
   rec_t          new_rec;
   rec_t          head_rec;

   assign req_slot  = id_cnt[AW-1:0];
   assign resp_slot = bus.resp_id[AW-1:0];

   // Ready depends only on table state and reset, never on this cycle's response.
   assign bus.req_ready = reset && !tbl_valid[req_slot];
   assign bus.req_id    = id_cnt;
   assign accept        = bus.req_valid && bus.req_ready;

   assign resp_match = bus.resp_fire && tbl_valid[resp_slot] &&
                       (tbl_id[resp_slot] == bus.resp_id);

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[SAW] != rd_ptr[SAW]) &&
                       (wr_ptr[SAW-1:0] == rd_ptr[SAW-1:0]);
   assign pop        = !fifo_empty && bus.stat_ready;
   assign push_ok    = resp_match && (!fifo_full || pop);

   assign lat_diff = global_cycle - tbl_issue[resp_slot];

   always_comb begin
      new_rec             = '0;
      new_rec.id          = tbl_id[resp_slot];
      new_rec.addr        = tbl_addr[resp_slot];
      new_rec.is_write    = tbl_is_write[resp_slot];
      new_rec.issue_cycle = tbl_issue[resp_slot];
      new_rec.latency     = (|lat_diff[63:32]) ? 32'hFFFF_FFFF : lat_diff[31:0];
   end

   assign head_rec = fifo_empty ? '0 : fifo_mem[rd_ptr[SAW-1:0]];

   assign bus.stat_valid       = !fifo_empty;
   assign bus.stat_id          = head_rec.id;
   assign bus.stat_addr        = head_rec.addr;
   assign bus.stat_is_write    = head_rec.is_write;
   assign bus.stat_issue_cycle = head_rec.issue_cycle;
   assign bus.stat_latency     = head_rec.latency;

   always_ff @(posedge clk) begin
      if (!reset) begin
         id_cnt        <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         outstanding   <= '0;
         err_unmatched <= 1'b0;
         err_overflow  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_valid[i] <= 1'b0;
         end
      end else begin
         // Accept and match can never target the same slot: accept needs it empty, match needs it full.
         if (accept) begin
            id_cnt                 <= id_cnt + 32'd1;
            tbl_valid[req_slot]    <= 1'b1;
            tbl_id[req_slot]       <= id_cnt;
            tbl_addr[req_slot]     <= bus.req_addr;
            tbl_is_write[req_slot] <= bus.req_is_write;
            tbl_issue[req_slot]    <= global_cycle;
         end

         if (resp_match) begin
            tbl_valid[resp_slot] <= 1'b0;
         end

         if (push_ok) begin
            fifo_mem[wr_ptr[SAW-1:0]] <= new_rec;
            wr_ptr                    <= wr_ptr + PTR_ONE;
         end

         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         if (resp_match && !push_ok) begin
            err_overflow <= 1'b1;
         end

         if (bus.resp_fire && !resp_match) begin
            err_unmatched <= 1'b1;
         end

         case ({accept, resp_match})
            2'b10:   outstanding <= outstanding + OUT_ONE;
            2'b01:   outstanding <= outstanding - OUT_ONE;
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_cmdq_request_latency_tracker.sv
// Directed-vector bench for cmdq_request_latency_tracker with hand-computed expected records.
module tb_cmdq_request_latency_tracker;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] global_cycle = '0;
   logic [4:0]  outstanding;
   logic        err_unmatched;
   logic        err_overflow;

   int checks = 0;
   int errors = 0;

   cmdq_request_latency_tracker_if bus();

   cmdq_request_latency_tracker #(.DEPTH(16), .STAT_DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .global_cycle  (global_cycle),
      .outstanding   (outstanding),
      .err_unmatched (err_unmatched),
      .err_overflow  (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic do_req(input logic [31:0] addr, input logic wr);
      bus.req_valid    = 1'b1;
      bus.req_addr     = addr;
      bus.req_is_write = wr;
      tick();
      bus.req_valid    = 1'b0;
   endtask

   task automatic do_resp(input logic [31:0] id);
      bus.resp_fire = 1'b1;
      bus.resp_id   = id;
      tick();
      bus.resp_fire = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [31:0] id, input logic [31:0] addr,
                            input logic wr, input logic [63:0] issue, input logic [31:0] lat);
      chk({tag, "_vld"}, bus.stat_valid, 1);
      chk({tag, "_id"}, bus.stat_id, id);
      chk({tag, "_addr"}, bus.stat_addr, addr);
      chk({tag, "_wr"}, bus.stat_is_write, wr);
      chk({tag, "_issue"}, bus.stat_issue_cycle, issue);
      chk({tag, "_lat"}, bus.stat_latency, lat);
      bus.stat_ready = 1'b1;
      tick();
      bus.stat_ready = 1'b0;
   endtask

   initial begin
      int n;
      bus.req_valid    = 1'b0;
      bus.req_addr     = '0;
      bus.req_is_write = 1'b0;
      bus.resp_fire    = 1'b0;
      bus.resp_id      = '0;
      bus.stat_ready   = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_req_id", bus.req_id, 0);
      chk("rst_stat_valid", bus.stat_valid, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err_unm", err_unmatched, 0);
      chk("rst_err_ovf", err_overflow, 0);
      reset = 1'b1;
      #1;
      chk("post_rst_ready", bus.req_ready, 1);

      // Single round-trip
      global_cycle = 64'd10;
      do_req(32'h100, 1'b0);
      chk("rt_outstanding1", outstanding, 1);
      chk("rt_req_id1", bus.req_id, 1);
      chk("rt_no_rec", bus.stat_valid, 0);
      global_cycle = 64'd25;
      do_resp(32'd0);
      chk("rt_outstanding0", outstanding, 0);
      pop_check("rt", 32'd0, 32'h100, 1'b0, 64'd10, 32'd15);
      chk("rt_drained", bus.stat_valid, 0);

      // Out-of-order completion
      do_reset();
      global_cycle = 64'd100; do_req(32'hA00, 1'b0);
      global_cycle = 64'd101; do_req(32'hB04, 1'b1);
      global_cycle = 64'd102; do_req(32'hC08, 1'b0);
      chk("ooo_outstanding3", outstanding, 3);
      global_cycle = 64'd110; do_resp(32'd2);
      global_cycle = 64'd111; do_resp(32'd0);
      global_cycle = 64'd112; do_resp(32'd1);
      chk("ooo_outstanding0", outstanding, 0);
      pop_check("ooo_r0", 32'd2, 32'hC08, 1'b0, 64'd102, 32'd8);
      pop_check("ooo_r1", 32'd0, 32'hA00, 1'b0, 64'd100, 32'd11);
      pop_check("ooo_r2", 32'd1, 32'hB04, 1'b1, 64'd101, 32'd11);
      chk("ooo_err_unm", err_unmatched, 0);

      // Table full / slot conflict
      do_reset();
      global_cycle = 64'd200;
      for (int i = 0; i < 16; i++) do_req(32'h1000 + 32'(i) * 4, 1'b0);
      chk("full_ready", bus.req_ready, 0);
      chk("full_req_id", bus.req_id, 16);
      chk("full_outstanding", outstanding, 16);
      do_req(32'hDEAD, 1'b1);
      chk("full_blocked_id", bus.req_id, 16);
      global_cycle = 64'd300;
      do_resp(32'd0);
      chk("full_ready_back", bus.req_ready, 1);
      chk("full_outstanding15", outstanding, 15);
      global_cycle = 64'd301;
      do_req(32'h2000, 1'b1);
      chk("full_wrap_id", bus.req_id, 17);
      global_cycle = 64'd310;
      do_resp(32'd16);
      pop_check("full_r0", 32'd0, 32'h1000, 1'b0, 64'd200, 32'd100);
      pop_check("full_r1", 32'd16, 32'h2000, 1'b1, 64'd301, 32'd9);

      // Unmatched response, including a stale ID whose slot holds a newer request
      do_reset();
      do_resp(32'd5);
      chk("unm_err", err_unmatched, 1);
      chk("unm_no_rec", bus.stat_valid, 0);
      chk("unm_outstanding", outstanding, 0);
      do_reset();
      chk("unm_cleared", err_unmatched, 0);
      global_cycle = 64'd50;
      do_req(32'h40, 1'b0);
      do_resp(32'd16);
      chk("stale_err", err_unmatched, 1);
      chk("stale_outstanding", outstanding, 1);
      chk("stale_no_rec", bus.stat_valid, 0);

      // FIFO overflow
      do_reset();
      global_cycle = 64'd1000;
      for (int i = 0; i < 5; i++) do_req(32'h500 + 32'(i), 1'b0);
      global_cycle = 64'd1020;
      for (int i = 0; i < 4; i++) do_resp(32'(i));
      chk("ovf_not_yet", err_overflow, 0);
      do_resp(32'd4);
      chk("ovf_err", err_overflow, 1);
      chk("ovf_outstanding", outstanding, 0);
      chk("ovf_ready", bus.req_ready, 1);
      n = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.stat_valid) begin
            chk("ovf_drain_id", bus.stat_id, 32'(k));
            bus.stat_ready = 1'b1;
            tick();
            bus.stat_ready = 1'b0;
            n++;
         end
      end
      chk("ovf_drain_cnt", n, 4);

      // Push and pop in the same cycle while full
      do_reset();
      global_cycle = 64'd2000;
      for (int i = 0; i < 5; i++) do_req(32'h600 + 32'(i), 1'b1);
      global_cycle = 64'd2003;
      for (int i = 0; i < 4; i++) do_resp(32'(i));
      bus.stat_ready = 1'b1;
      do_resp(32'd4);
      bus.stat_ready = 1'b0;
      chk("pp_no_ovf", err_overflow, 0);
      pop_check("pp_r1", 32'd1, 32'h601, 1'b1, 64'd2000, 32'd3);
      pop_check("pp_r2", 32'd2, 32'h602, 1'b1, 64'd2000, 32'd3);
      pop_check("pp_r3", 32'd3, 32'h603, 1'b1, 64'd2000, 32'd3);
      pop_check("pp_r4", 32'd4, 32'h604, 1'b1, 64'd2000, 32'd3);
      chk("pp_empty", bus.stat_valid, 0);

      // Saturation boundary
      do_reset();
      global_cycle = 64'd0;
      do_req(32'h700, 1'b0);
      do_req(32'h704, 1'b1);
      global_cycle = 64'h1_0000_0005;
      do_resp(32'd0);
      pop_check("sat", 32'd0, 32'h700, 1'b0, 64'd0, 32'hFFFF_FFFF);
      global_cycle = 64'hFFFF_FFFE;
      do_resp(32'd1);
      pop_check("nosat", 32'd1, 32'h704, 1'b1, 64'd0, 32'hFFFF_FFFE);

      // Reset mid-flight
      do_reset();
      global_cycle = 64'd40;
      for (int i = 0; i < 4; i++) do_req(32'h800 + 32'(i), 1'b0);
      do_resp(32'd3);
      do_resp(32'd9);
      chk("mid_outstanding3", outstanding, 3);
      chk("mid_rec_pending", bus.stat_valid, 1);
      reset = 1'b0;
      tick();
      chk("mid_outstanding", outstanding, 0);
      chk("mid_stat_valid", bus.stat_valid, 0);
      chk("mid_stat_id", bus.stat_id, 0);
      chk("mid_stat_addr", bus.stat_addr, 0);
      chk("mid_stat_lat", bus.stat_latency, 0);
      chk("mid_err_unm", err_unmatched, 0);
      chk("mid_req_ready", bus.req_ready, 0);
      chk("mid_req_id", bus.req_id, 0);
      reset = 1'b1;
      global_cycle = 64'd60;
      do_req(32'h900, 1'b1);
      chk("mid_next_id", bus.req_id, 1);
      global_cycle = 64'd64;
      do_resp(32'd0);
      pop_check("mid_r0", 32'd0, 32'h900, 1'b1, 64'd60, 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmdq_request_latency_tracker.md
# cmdq_request_latency_tracker

Request-side counterpart to the command-queue response statistics logger. It sits on the request path into the memory controller's command queue and assigns sequential request IDs. For each accepted request it timestamps the issue cycle, address and type. When the matching response fires, it pairs the response with the stored request and streams out a per-request latency record through a small valid/ready FIFO. The block is fully synthesizable, so latency statistics are available on-chip as well as in simulation.

## Interface
Parameters:
- DEPTH, 16, outstanding-request table entries; power of two, ≥2
- STAT_DEPTH, 4, latency-record FIFO entries; power of two, ≥2

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  upstream request valid
- req_ready  out  1  tracker can accept a request
- req_addr  in  32  request address
- req_is_write  in  1  request type: 1 = write, 0 = read
- req_id  out  32  ID that the next accepted request will carry
- resp_fire  in  1  response handshake completed this cycle; cannot be stalled
- resp_id  in  32  ID of the responding request
- global_cycle  in  64  free-running cycle counter
- stat_valid  out  1  latency record available
- stat_ready  in  1  consumer accepts record
- stat_id  out  32  record: request ID
- stat_addr  out  32  record: address
- stat_is_write  out  1  record: type
- stat_issue_cycle  out  64  record: global_cycle value at accept
- stat_latency  out  32  record: response cycle minus issue cycle, saturated
- outstanding  out  $clog2(DEPTH)+1  count of valid table entries
- err_unmatched  out  1  sticky: a response ID had no matching entry
- err_overflow  out  1  sticky: a record was dropped because the FIFO was full

## Operation
- ID counter: 32-bit, reset 0. It increments by 1 on each accept (req_valid && req_ready) and wraps 0xFFFFFFFF→0. req_id = counter.
- Table slot = id[$clog2(DEPTH)-1:0]. Each slot holds valid, the full 32-bit id, addr, is_write and issue_cycle.
- req_ready = reset deasserted && !slot[req_id].valid. This is registered state only; there is no combinational path from resp_fire.
- Accept: write the slot with valid=1, req_id, req_addr, req_is_write and the current global_cycle.
- Response: look up slot[resp_id]. A match requires valid && stored id == resp_id.
  - On a match: clear valid, compute the record, and push it to the FIFO.
  - On no match: set err_unmatched, push nothing, and leave the table unchanged.
- Latency: 64-bit subtraction of global_cycle − issue_cycle, modulo 2^64. If the result is > 0xFFFFFFFF, stat_latency = 0xFFFFFFFF.
- FIFO behaviour:
  - Push when full and not popping in the same cycle: drop the record and set err_overflow. The table slot is still freed.
  - Push and pop in the same cycle while full: both succeed.
- outstanding: +1 on accept, −1 on a matched response, unchanged when both occur in the same cycle.
- Simultaneous accept and response on the same ID: impossible, because the response lookup sees the pre-edge table. Such a response is unmatched.
- Responses may arrive in any order.
- Error flags clear only on reset.

## Timing
- Reset (reset=0 sampled at posedge) clears:
  - ID counter, all valid bits, and the FIFO pointers.
  - outstanding, err_unmatched and err_overflow go to 0.
  - stat_valid goes to 0; stat_* data outputs go to 0.
  - req_ready is 0 while reset is low.
- Reset mid-operation discards all outstanding entries and queued records. The first post-reset accept gets ID 0.
- Accept takes effect at the edge; outstanding and req_id update the next cycle.
- Record latency: resp_fire sampled at edge N gives stat_valid=1 in cycle N+1, provided the FIFO was empty.
- FIFO is first-word-fall-through. stat_* holds stable while stat_valid && !stat_ready.
- Pop occurs at an edge where stat_valid && stat_ready.
- err_* assert the cycle after the offending edge.

## Test plan
- **Single round-trip:**
  - Stimulus: after reset, accept addr 0x100 read at cycle 10; resp_fire with resp_id 0 at cycle 25.
  - Required: the record has stat_id=0, stat_addr=0x100, stat_is_write=0, stat_issue_cycle=10 and stat_latency=15. outstanding goes 0→1→0.
- **Out-of-order completion:**
  - Stimulus: accept IDs 0,1,2; respond 2, 0, 1.
  - Required: three records emerge in response order with correct addresses; err_unmatched stays 0.
- **Table full / slot conflict:**
  - Stimulus: DEPTH=16; accept 16 requests with no responses.
  - Required: req_ready=0 with req_id=16. After a response to ID 0, req_ready returns to 1 the next cycle.
- **Unmatched response:**
  - Stimulus: resp_id 5 with an empty table.
  - Required: err_unmatched=1 next cycle, no record, and outstanding stays 0.
- **FIFO overflow:**
  - Stimulus: hold stat_ready=0; complete 5 requests with STAT_DEPTH=4.
  - Required: 4 records are held, err_overflow=1, and outstanding=0. After stat_ready=1, exactly 4 records drain.
- **Saturation and reset mid-flight:**
  - Saturation: issue_cycle 0, response at global_cycle 0x1_0000_0005 → stat_latency=0xFFFFFFFF.
  - Reset mid-flight: assert reset with 3 requests outstanding. Required: all outputs return to 0 and the next accept gets req_id 0.
